datapath_xyz: RTL and testbench

DATAPATH_XYZ -- requirements
Module: datapath_xyz

---
 rtl/datapath_xyz.sv | 150 +++++++++++++++
 tb/tb_datapath_xyz.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/datapath_xyz.sv
// -----------------------------------------------------------------------------
// datapath_xyz
// Three-register datapath: X operand register, Y accumulator with add/subtract
// ALU and logical shifts, Z result register that captures the previous Y.
// All registers update together on the rising clock edge when en is high.
// Every register samples the pre-edge values of X, Y and Z.
//
// Optional feature: define DATAPATH_OVF_EN to build the signed-overflow flag.
// Without it, ovf is tied low.
//
// Ports
//   clk     in   1   clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   en      in   1   operation strobe; commands apply only when high
//   din     in   N   operand loaded into X
//   auxX    in   2   X command: 00 clear, 01 load din, 10/11 hold
//   auxY    in   3   Y command: 000 clear, 001 load ALU, 010 hold,
//                    011 shift left, 100 shift right, 101-111 hold
//   auxZ    in   2   Z command: 00 clear, 01 load old Y, 10/11 hold
//   auxULA  in   1   ALU op: 0 Y+X, 1 Y-X
//   X       out  N   X register
//   Y       out  N   Y accumulator
//   Z       out  N   Z result register
//   zero    out  1   registered, high when Y is zero after the last update
//   ovf     out  1   registered signed overflow of the last Y load
// -----------------------------------------------------------------------------
module datapath_xyz #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] din,
    input  logic [1:0]   auxX,
    input  logic [2:0]   auxY,
    input  logic [1:0]   auxZ,
    input  logic         auxULA,
    output logic [N-1:0] X,
    output logic [N-1:0] Y,
    output logic [N-1:0] Z,
    output logic         zero,
    output logic         ovf
);

    localparam logic [1:0] XZ_CLEAR = 2'b00;
    localparam logic [1:0] XZ_LOAD  = 2'b01;

    localparam logic [2:0] Y_CLEAR = 3'b000;
    localparam logic [2:0] Y_LOAD  = 3'b001;
    localparam logic [2:0] Y_SHL   = 3'b011;
    localparam logic [2:0] Y_SHR   = 3'b100;

    logic [N-1:0] r_x;
    logic [N-1:0] r_y;
    logic [N-1:0] r_z;
    logic         r_zero;

    logic [N-1:0] w_alu;
    logic [N-1:0] w_x_next;
    logic [N-1:0] w_y_next;
    logic [N-1:0] w_z_next;

    assign w_alu = auxULA ? (r_y - r_x) : (r_y + r_x);

    always_comb begin
        w_x_next = r_x;
        case (auxX)
            XZ_CLEAR: w_x_next = '0;
            XZ_LOAD:  w_x_next = din;
            default:  w_x_next = r_x;
        endcase
    end

    always_comb begin
        w_z_next = r_z;
        case (auxZ)
            XZ_CLEAR: w_z_next = '0;
            XZ_LOAD:  w_z_next = r_y;
            default:  w_z_next = r_z;
        endcase
    end

    always_comb begin
        w_y_next = r_y;
        case (auxY)
            Y_CLEAR: w_y_next = '0;
            Y_LOAD:  w_y_next = w_alu;
            Y_SHL:   w_y_next = {r_y[N-2:0], 1'b0};
            Y_SHR:   w_y_next = {1'b0, r_y[N-1:1]};
            default: w_y_next = r_y;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_zero <= 1'b1;
        end else if (en) begin
            r_x    <= w_x_next;
            r_y    <= w_y_next;
            r_z    <= w_z_next;
            r_zero <= (w_y_next == '0);
        end
    end

`ifdef DATAPATH_OVF_EN
    logic r_ovf;
    logic w_alu_ovf;
    logic w_ovf_next;

    // Add overflows when both operands share a sign the result lacks.
    // Y-X overflows when the operands differ in sign and the result's sign
    // differs from Y's.
    always_comb begin
        w_alu_ovf = 1'b0;
        if (auxULA)
            w_alu_ovf = (r_y[N-1] != r_x[N-1]) && (w_alu[N-1] != r_y[N-1]);
        else
            w_alu_ovf = (r_y[N-1] == r_x[N-1]) && (w_alu[N-1] != r_y[N-1]);
    end

    always_comb begin
        w_ovf_next = r_ovf;
        case (auxY)
            Y_CLEAR: w_ovf_next = 1'b0;
            Y_LOAD:  w_ovf_next = w_alu_ovf;
            default: w_ovf_next = r_ovf;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ovf <= 1'b0;
        else if (en)
            r_ovf <= w_ovf_next;
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign X    = r_x;
    assign Y    = r_y;
    assign Z    = r_z;
    assign zero = r_zero;

endmodule

// File: tb/tb_datapath_xyz.sv
module tb_datapath_xyz;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] din;
    logic [1:0] auxX;
    logic [2:0] auxY;
    logic [1:0] auxZ;
    logic       auxULA;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] Z;
    logic       zero;
    logic       ovf;

    int total = 0;
    int bad   = 0;

`ifdef DATAPATH_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    datapath_xyz #(.N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .din    (din),
        .auxX   (auxX),
        .auxY   (auxY),
        .auxZ   (auxZ),
        .auxULA (auxULA),
        .X      (X),
        .Y      (Y),
        .Z      (Z),
        .zero   (zero),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command between edges, then sample 1 time unit after the edge.
    task automatic step(input logic e, input logic [3:0] d, input logic [1:0] ax,
                        input logic [2:0] ay, input logic [1:0] az, input logic ula);
        @(negedge clk);
        en = e; din = d; auxX = ax; auxY = ay; auxZ = az; auxULA = ula;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din = '0;
        auxX = 2'b10; auxY = 3'b010; auxZ = 2'b10; auxULA = 1'b0;
        #3;
        chk("rst_x", X, 0);
        chk("rst_y", Y, 0);
        chk("rst_z", Z, 0);
        chk("rst_zero", zero, 1);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // load / add
        step(1, 4'd3, 2'b01, 3'b010, 2'b10, 0);
        chk("ld_x", X, 3);
        chk("ld_zero", zero, 1);
        step(1, 4'd0, 2'b10, 3'b001, 2'b10, 0);
        chk("add1_y", Y, 3);
        chk("add1_zero", zero, 0);
        step(1, 4'd0, 2'b10, 3'b001, 2'b10, 0);
        chk("add2_y", Y, 6);

        // asynchronous reset in the middle of a pending add
        @(negedge clk);
        auxY = 3'b001;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_x", X, 0);
        chk("arst_y", Y, 0);
        chk("arst_z", Z, 0);
        chk("arst_zero", zero, 1);
        chk("arst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // subtract: X=2, Y=5
        step(1, 4'd5, 2'b01, 3'b010, 2'b10, 0);
        step(1, 4'd2, 2'b01, 3'b001, 2'b10, 0);
        chk("sub_setup_x", X, 2);
        chk("sub_setup_y", Y, 5);
        step(1, 4'd3, 2'b01, 3'b001, 2'b10, 1);
        chk("sub1_y", Y, 3);
        chk("sub1_zero", zero, 0);
        step(1, 4'd0, 2'b10, 3'b001, 2'b10, 1);
        chk("sub2_y", Y, 0);
        chk("sub2_zero", zero, 1);

        // overflow: X=1, Y=7, add -> 8
        step(1, 4'd7, 2'b01, 3'b010, 2'b10, 0);
        step(1, 4'd1, 2'b01, 3'b001, 2'b10, 0);
        chk("ovf_setup_y", Y, 7);
        chk("ovf_setup_ovf", ovf, 0);
        step(1, 4'd0, 2'b10, 3'b001, 2'b10, 0);
        chk("ovf_y", Y, 8);
        chk("ovf_flag", ovf, {7'd0, OVF_ON});
        step(1, 4'd0, 2'b10, 3'b010, 2'b10, 0);
        chk("ovf_hold", ovf, {7'd0, OVF_ON});
        step(1, 4'd0, 2'b10, 3'b000, 2'b10, 0);
        chk("ovf_clr_y", Y, 0);
        chk("ovf_clr", ovf, 0);
        chk("ovf_clr_zero", zero, 1);

        // shifts and transfer
        step(1, 4'hA, 2'b01, 3'b000, 2'b10, 0);
        step(1, 4'd0, 2'b10, 3'b001, 2'b10, 0);
        chk("shift_setup_y", Y, 4'hA);
        step(1, 4'd0, 2'b10, 3'b100, 2'b10, 0);
        chk("shr_y", Y, 4'h5);
        step(1, 4'd0, 2'b10, 3'b011, 2'b10, 0);
        chk("shl_y", Y, 4'hA);
        step(1, 4'd5, 2'b11, 3'b111, 2'b11, 0);
        chk("undef_x", X, 4'hA);
        chk("undef_y", Y, 4'hA);
        chk("undef_z", Z, 0);
        chk("undef_zero", zero, 0);
        step(1, 4'd0, 2'b00, 3'b000, 2'b01, 0);
        chk("xfer_z", Z, 4'hA);
        chk("xfer_x", X, 0);
        chk("xfer_y", Y, 0);
        chk("xfer_zero", zero, 1);

        // en gating
        step(0, 4'd9, 2'b01, 3'b001, 2'b00, 0);
        chk("gate_x", X, 0);
        chk("gate_z", Z, 4'hA);
        chk("gate_zero", zero, 1);

        // simultaneity: X=2, Y=4, then load X=5 while Y adds old X
        step(1, 4'd4, 2'b01, 3'b000, 2'b10, 0);
        step(1, 4'd2, 2'b01, 3'b001, 2'b10, 0);
        chk("sim_setup_x", X, 2);
        chk("sim_setup_y", Y, 4);
        step(1, 4'd5, 2'b01, 3'b001, 2'b01, 0);
        chk("sim_x", X, 5);
        chk("sim_y", Y, 6);
        chk("sim_z", Z, 4);

        // subtract overflow: Y=6 - X=(-3) = 9 -> signed overflow
        step(1, 4'hD, 2'b01, 3'b010, 2'b10, 0);
        step(1, 4'd0, 2'b10, 3'b001, 2'b10, 1);
        chk("subovf_y", Y, 9);
        chk("subovf_flag", ovf, {7'd0, OVF_ON});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
